// File: rtl/remote_link_pkg.sv
// Shared definitions for the player-state serial link (receiver now, packer later).
package remote_link_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {HUNT, B0, B1, B2, CHK} pkt_state_t;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} bit_state_t;

    function automatic logic [7:0] pkt_chk(input logic [7:0] b0,
                                           input logic [7:0] b1,
                                           input logic [7:0] b2);
        return b0 ^ b1 ^ b2;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling, glitch reject, frame-error report.
module uart_rx_byte
    import remote_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta, rx_s;
    bit_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_valid_d, frame_err_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: if (cnt_q == HALF_LAST) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt_q == BIT_LAST) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                if (bit_q == 3'd7) state_d = STOP;
            end
            STOP: if (cnt_q == BIT_LAST) begin
                cnt_d = '0;
                if (rx_s) begin
                    byte_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            byte_valid <= byte_valid_d;
            frame_err  <= frame_err_d;
        end
    end

    assign data = shift_q;

endmodule

// File: rtl/remote_player_rx.sv
// Remote player-state receiver: deframes {SYNC,B0,B1,B2,CHK} into x/y/level.
// Optional inter-byte timeout enabled by defining REMOTE_RX_TIMEOUT_EN.
module remote_player_rx
    import remote_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
`ifdef REMOTE_RX_TIMEOUT_EN
    , parameter int TIMEOUT_BITS = 20
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [11:0] x_remote,
    output logic [11:0] y_remote,
    output logic [1:0]  level_remote,
    output logic        pkt_valid,
    output logic [7:0]  err_cnt
);

    logic       byte_valid, frame_err, timeout;
    logic [7:0] byte_data;
    logic [7:0] b0_q, b1_q, b2_q;
    pkt_state_t state_q, state_d;
    logic       load, err_inc;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_valid(byte_valid),
        .data      (byte_data),
        .frame_err (frame_err)
    );

`ifdef REMOTE_RX_TIMEOUT_EN
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW        = $clog2(TO_CYCLES);
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            idle_cnt <= '0;
        else if (state_q == HUNT || byte_valid) idle_cnt <= '0;
        else                                 idle_cnt <= idle_cnt + 1'b1;
    end

    // A byte landing on the last idle cycle still counts as on time.
    assign timeout = (idle_cnt == TW'(TO_CYCLES - 1)) && !byte_valid;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        err_inc = 1'b0;
        if (state_q != HUNT && (frame_err || timeout)) begin
            state_d = HUNT;
            err_inc = 1'b1;
        end else if (byte_valid) begin
            case (state_q)
                HUNT: if (byte_data == SYNC_BYTE) state_d = B0;
                B0:   state_d = B1;
                B1:   state_d = B2;
                B2:   state_d = CHK;
                CHK: begin
                    state_d = HUNT;
                    if (byte_data == pkt_chk(b0_q, b1_q, b2_q)) load    = 1'b1;
                    else                                        err_inc = 1'b1;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= HUNT;
            b0_q         <= '0;
            b1_q         <= '0;
            b2_q         <= '0;
            x_remote     <= '0;
            y_remote     <= '0;
            level_remote <= '0;
            pkt_valid    <= 1'b0;
            err_cnt      <= '0;
        end else begin
            state_q   <= state_d;
            pkt_valid <= load;
            if (byte_valid) begin
                case (state_q)
                    B0:      b0_q <= byte_data;
                    B1:      b1_q <= byte_data;
                    B2:      b2_q <= byte_data;
                    default: ;
                endcase
            end
            if (load) begin
                x_remote     <= {1'b0, b1_q[2:0], b0_q};
                y_remote     <= {1'b0, b2_q[5:0], b1_q[7:3]};
                level_remote <= b2_q[7:6];
            end
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_remote_player_rx.sv
// Scoreboard bench for remote_player_rx with a shortened bit time.
module tb_remote_player_rx;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic [11:0] x_remote, y_remote;
    logic [1:0]  level_remote;
    logic        pkt_valid;
    logic [7:0]  err_cnt;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic [1:0]  lvl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pkts   = 0;

    remote_player_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .x_remote    (x_remote),
        .y_remote    (y_remote),
        .level_remote(level_remote),
        .pkt_valid   (pkt_valid),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] s, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] c);
        send_byte(s);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(c);
    endtask

    task automatic expect_pkt(input logic [11:0] x, input logic [11:0] y, input logic [1:0] l);
        exp_t e;
        e.x   = x;
        e.y   = y;
        e.lvl = l;
        exp_q.push_back(e);
    endtask

    // Monitor: every pkt_valid pulse must match the oldest expected packet.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && pkt_valid) begin
                n_pkts++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pkt_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pkt_x", 32'(x_remote), 32'(e.x));
                    check("pkt_y", 32'(y_remote), 32'(e.y));
                    check("pkt_level", 32'(level_remote), 32'(e.lvl));
                end
            end
        end
    end

    initial begin
        repeat (4) @(negedge clk);
        check("reset_x", 32'(x_remote), 32'h0);
        check("reset_err", 32'(err_cnt), 32'h0);
        check("reset_pkt_valid", 32'(pkt_valid), 32'h0);
        rst = 1'b1;
        repeat (3 * CPB) @(negedge clk);

        // Good packet.
        expect_pkt(12'h123, 12'h0AB, 2'd2);
        send_pkt(8'hA5, 8'h23, 8'h59, 8'h85, 8'hFF);
        check("p1_err", 32'(err_cnt), 32'd0);

        // Bad checksum: outputs hold, error counted.
        send_pkt(8'hA5, 8'h23, 8'h59, 8'h85, 8'h00);
        check("p2_err", 32'(err_cnt), 32'd1);
        check("p2_x_hold", 32'(x_remote), 32'h123);
        check("p2_y_hold", 32'(y_remote), 32'h0AB);

        // Junk in HUNT, then SYNC value used as every payload byte.
        expect_pkt(12'h5A5, 12'h4B4, 2'd2);
        send_byte(8'h00);
        send_byte(8'h37);
        send_pkt(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
        check("p3_err", 32'(err_cnt), 32'd1);

        // Framing error on B1 aborts the packet.
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check("frame_err_cnt", 32'(err_cnt), 32'd2);
        expect_pkt(12'h201, 12'h060, 2'd3);
        send_pkt(8'hA5, 8'h01, 8'h02, 8'hC3, 8'hC0);
        check("p4_err", 32'(err_cnt), 32'd2);

        // Short glitch on idle line.
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_err", 32'(err_cnt), 32'd2);

        // Reset between B1 and B2.
        send_byte(8'hA5);
        send_byte(8'h23);
        send_byte(8'h59);
        rst = 1'b0;
        #1;
        check("mid_rst_x", 32'(x_remote), 32'h0);
        check("mid_rst_y", 32'(y_remote), 32'h0);
        check("mid_rst_level", 32'(level_remote), 32'h0);
        check("mid_rst_err", 32'(err_cnt), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (CPB) @(negedge clk);
        send_byte(8'h85);
        send_byte(8'hFF);
        check("post_rst_err", 32'(err_cnt), 32'd0);

        expect_pkt(12'h123, 12'h0AB, 2'd2);
        send_pkt(8'hA5, 8'h23, 8'h59, 8'h85, 8'hFF);
        check("p6_err", 32'(err_cnt), 32'd0);

`ifdef REMOTE_RX_TIMEOUT_EN
        send_byte(8'hA5);
        send_byte(8'h23);
        repeat (21 * CPB) @(negedge clk);
        check("timeout_err", 32'(err_cnt), 32'd1);
`endif

        repeat (4 * CPB) @(negedge clk);
        check("pending_expected", 32'(exp_q.size()), 32'd0);
        check("pkt_count", 32'(n_pkts), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
